// File: rtl/iot_event_arbiter_if.sv
// ---------------------------------------------------------------------------
// iot_event_arbiter_if
// Bundles the requester-side handshake and the monitor-side event signals of
// the IoT event arbiter so that the arbiter and its users share one port.
//
// Signals:
//   req        requester -> arbiter  per-device request level, held until ack
//   req_on     requester -> arbiter  requested state per device (1=on, 0=off)
//   clr        requester -> arbiter  synchronous clear of state map and monitor
//   ack        arbiter -> requester  one-cycle grant, one-hot or zero
//   change     arbiter -> monitor    one-cycle event pulse
//   on_off     arbiter -> monitor    event direction, valid while change=1
//   mon_rst    arbiter -> monitor    one-cycle monitor clear pulse
//   active_map arbiter -> user       current on/off state per device
//   active_cnt arbiter -> user       number of devices currently on
//   busy       arbiter -> user       high while the arbiter holds a grant
//
// Modports: master is the requester/monitor side, slave is the arbiter.
// ---------------------------------------------------------------------------
interface iot_event_arbiter_if #(
  parameter int N_DEV = 4,
  parameter int CW    = 5
);

  logic [N_DEV-1:0] req;
  logic [N_DEV-1:0] req_on;
  logic             clr;
  logic [N_DEV-1:0] ack;
  logic             change;
  logic             on_off;
  logic             mon_rst;
  logic [N_DEV-1:0] active_map;
  logic [CW-1:0]    active_cnt;
  logic             busy;

  modport master (
    output req, req_on, clr,
    input  ack, change, on_off, mon_rst, active_map, active_cnt, busy
  );

  modport slave (
    input  req, req_on, clr,
    output ack, change, on_off, mon_rst, active_map, active_cnt, busy
  );

endinterface

// File: rtl/iot_event_arbiter.sv
// ---------------------------------------------------------------------------
// iot_event_arbiter
// Shares the single change/on_off event input of the active-device monitor
// among N_DEV requesters. Pending requests are granted round-robin, one every
// two cycles, and each grant emits at most one event. The arbiter keeps its
// own copy of every device's on/off state and drops redundant requests (ON
// while on, OFF while off), so the monitor count always equals the number
// of active devices and can never wrap.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    iot_event_arbiter_if.slave (req, req_on, clr in; ack, change,
//          on_off, mon_rst, active_map, active_cnt, busy out)
//
// Parameters:
//   N_DEV  number of requesters, 2..16
//   CW     width of active_cnt, 2**CW must exceed N_DEV
// ---------------------------------------------------------------------------
module iot_event_arbiter #(
  parameter int N_DEV = 4,
  parameter int CW    = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  iot_event_arbiter_if.slave bus
);

  localparam int PW = (N_DEV > 1) ? $clog2(N_DEV) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e           state_q;
  logic [PW-1:0]    ptr_q;
  logic [N_DEV-1:0] ack_q;
  logic             change_q;
  logic             onOff_q;
  logic             monRst_q;
  logic [N_DEV-1:0] activeMap_q;
  logic [CW-1:0]    activeCnt_q;
  logic             busy_q;

  logic             winValid;
  logic [PW-1:0]    winIdx;
  logic [PW:0]      candSum;

  // Round-robin winner search. Candidates are visited from farthest
  // (ptr itself) to nearest (ptr+1); each hit overwrites the previous one,
  // so the nearest requester after ptr ends up as the winner. The sum is
  // one bit wider so a single conditional subtract gives the modulo even
  // when N_DEV is not a power of two.
  always_comb begin
    winValid = 1'b0;
    winIdx   = ptr_q;
    candSum  = '0;
    for (int k = N_DEV; k >= 1; k--) begin
      candSum = {1'b0, ptr_q} + (PW+1)'(k);
      if (candSum >= (PW+1)'(N_DEV)) begin
        candSum = candSum - (PW+1)'(N_DEV);
      end
      if (bus.req[candSum[PW-1:0]]) begin
        winValid = 1'b1;
        winIdx   = candSum[PW-1:0];
      end
    end
  end

  // Control FSM with every output registered. Clear beats everything else
  // but leaves the pointer alone, so fairness carries across a clear. A
  // grant in IDLE always moves to HOLD, which guarantees the requester has
  // one cycle to drop req before it could be sampled again. The counter is
  // only stepped together with an actual change event, which keeps it equal
  // to the population count of the map without a popcount adder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= PW'(N_DEV - 1);
      ack_q       <= '0;
      change_q    <= 1'b0;
      onOff_q     <= 1'b0;
      monRst_q    <= 1'b0;
      activeMap_q <= '0;
      activeCnt_q <= '0;
      busy_q      <= 1'b0;
    end else if (bus.clr) begin
      state_q     <= IDLE;
      ack_q       <= '0;
      change_q    <= 1'b0;
      onOff_q     <= 1'b0;
      monRst_q    <= 1'b1;
      activeMap_q <= '0;
      activeCnt_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      monRst_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (winValid) begin
            state_q <= HOLD;
            ptr_q   <= winIdx;
            ack_q   <= {{(N_DEV-1){1'b0}}, 1'b1} << winIdx;
            busy_q  <= 1'b1;
            if (bus.req_on[winIdx] != activeMap_q[winIdx]) begin
              change_q            <= 1'b1;
              onOff_q             <= bus.req_on[winIdx];
              activeMap_q[winIdx] <= bus.req_on[winIdx];
              if (bus.req_on[winIdx]) begin
                activeCnt_q <= activeCnt_q + CW'(1);
              end else begin
                activeCnt_q <= activeCnt_q - CW'(1);
              end
            end else begin
              change_q <= 1'b0;
              onOff_q  <= 1'b0;
            end
          end else begin
            ack_q    <= '0;
            change_q <= 1'b0;
            onOff_q  <= 1'b0;
            busy_q   <= 1'b0;
          end
        end
        HOLD: begin
          state_q  <= IDLE;
          ack_q    <= '0;
          change_q <= 1'b0;
          onOff_q  <= 1'b0;
          busy_q   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack        = ack_q;
  assign bus.change     = change_q;
  assign bus.on_off     = onOff_q;
  assign bus.mon_rst    = monRst_q;
  assign bus.active_map = activeMap_q;
  assign bus.active_cnt = activeCnt_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_iot_event_arbiter.sv
// ---------------------------------------------------------------------------
// tb_iot_event_arbiter
// Directed and randomized bench for iot_event_arbiter. Expected outputs come
// from a transaction-level model: a set of pending requesters, a rotating
// "last served" device, and the on/off state of every device, with the
// expected count taken as the number of devices that are on.
// ---------------------------------------------------------------------------
module tb_iot_event_arbiter;

  localparam int N  = 4;
  localparam int CW = 5;

  logic clk;
  logic rst_n;

  iot_event_arbiter_if #(.N_DEV(N), .CW(CW)) bus ();

  iot_event_arbiter #(.N_DEV(N), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total;
  int bad;

  // Requester-side intent: who is asking and for which state.
  logic [N-1:0] reqHold;
  logic [N-1:0] onHold;

  // Reference model state and expected outputs.
  logic [N-1:0] mMap;
  logic [N-1:0] expAck;
  int           mLast;
  bit           mHold;
  bit           expChange;
  bit           expOnOff;
  bit           expMonRst;
  bit           expBusy;

  function automatic bit bitOf(logic [N-1:0] v, int i);
    return ((32'(v) >> i) & 32'd1) != 32'd0;
  endfunction

  function automatic logic [N-1:0] maskOf(int i);
    return N'(1) << i;
  endfunction

  // Back to the power-up picture: nobody on, device N-1 counts as last
  // served, so device 0 is first in line.
  function automatic void modelReset();
    mMap      = '0;
    mLast     = N - 1;
    mHold     = 1'b0;
    expAck    = '0;
    expChange = 1'b0;
    expOnOff  = 1'b0;
    expMonRst = 1'b0;
    expBusy   = 1'b0;
  endfunction

  // One clock edge of the arbiter's contract: a clear wipes the state map,
  // otherwise a grant is handed out every other cycle to the first pending
  // device after the last one served, and only real state changes become
  // events.
  function automatic void modelStep(logic [N-1:0] r, logic [N-1:0] on, bit c);
    int w;
    expAck    = '0;
    expChange = 1'b0;
    expOnOff  = 1'b0;
    expBusy   = 1'b0;
    if (c) begin
      expMonRst = 1'b1;
      mMap      = '0;
      mHold     = 1'b0;
    end else begin
      expMonRst = 1'b0;
      if (mHold) begin
        mHold = 1'b0;
      end else if (r != '0) begin
        w = -1;
        for (int k = 1; k <= N; k++) begin
          if (w < 0 && bitOf(r, (mLast + k) % N)) w = (mLast + k) % N;
        end
        expAck  = maskOf(w);
        expBusy = 1'b1;
        mLast   = w;
        mHold   = 1'b1;
        if (bitOf(on, w) != bitOf(mMap, w)) begin
          expChange = 1'b1;
          expOnOff  = bitOf(on, w);
          mMap      = bitOf(on, w) ? (mMap | maskOf(w)) : (mMap & ~maskOf(w));
        end
      end
    end
  endfunction

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against the model; on_off is only meaningful
  // while an event is being issued.
  task automatic checkOutput(input string tag);
    checkEq({tag, ".ack"},     32'(bus.ack),        32'(expAck));
    checkEq({tag, ".change"},  32'(bus.change),     32'(expChange));
    checkEq({tag, ".mon_rst"}, 32'(bus.mon_rst),    32'(expMonRst));
    checkEq({tag, ".map"},     32'(bus.active_map), 32'(mMap));
    checkEq({tag, ".cnt"},     32'(bus.active_cnt), 32'($countones(mMap)));
    checkEq({tag, ".busy"},    32'(bus.busy),       32'(expBusy));
    if (expChange) checkEq({tag, ".on_off"}, 32'(bus.on_off), 32'(expOnOff));
  endtask

  // Drive one cycle of requests, step past the edge, check, then let the
  // acknowledged requester drop its request as the handshake demands.
  task automatic applyStimulus(input bit c, input string tag);
    bus.req    = reqHold;
    bus.req_on = onHold;
    bus.clr    = c;
    @(posedge clk);
    #1;
    modelStep(reqHold, onHold, c);
    checkOutput(tag);
    reqHold = reqHold & ~expAck;
  endtask

  task automatic doReset(input string tag);
    bus.req    = '0;
    bus.req_on = '0;
    bus.clr    = 1'b0;
    reqHold    = '0;
    rst_n      = 1'b0;
    #2;
    modelReset();
    checkOutput(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reqHold = '0;
    onHold  = '0;
    bus.req    = '0;
    bus.req_on = '0;
    bus.clr    = 1'b0;
    rst_n      = 1'b0;
    modelReset();

    // Reset state
    #12;
    doReset("reset");
    $display("[TB] reset done");

    // Single ON request from device 0, then the HOLD cycle
    reqHold = 4'b0001;
    onHold  = 4'b0001;
    applyStimulus(1'b0, "t1grant");
    checkEq("t1ack",    32'(bus.ack),        32'd1);
    checkEq("t1on_off", 32'(bus.on_off),     32'd1);
    checkEq("t1cnt",    32'(bus.active_cnt), 32'd1);
    applyStimulus(1'b0, "t1hold");
    checkEq("t1ackoff", 32'(bus.ack),        32'd0);
    checkEq("t1chgoff", 32'(bus.change),     32'd0);

    // Clear, then a real and a redundant ON from device 2
    applyStimulus(1'b1, "t2clr");
    checkEq("t2monrst", 32'(bus.mon_rst), 32'd1);
    applyStimulus(1'b0, "t2idle");
    checkEq("t2monrst0", 32'(bus.mon_rst), 32'd0);
    reqHold = 4'b0100;
    onHold  = 4'b0100;
    applyStimulus(1'b0, "t2grant");
    applyStimulus(1'b0, "t2hold");
    reqHold = 4'b0100;
    applyStimulus(1'b0, "t2redundant");
    checkEq("t2ack",    32'(bus.ack),        32'd4);
    checkEq("t2change", 32'(bus.change),     32'd0);
    checkEq("t2cnt",    32'(bus.active_cnt), 32'd1);
    applyStimulus(1'b0, "t2hold2");

    // All four request ON together, then all four request OFF
    doReset("t3reset");
    reqHold = 4'b1111;
    onHold  = 4'b1111;
    for (int i = 0; i < N; i++) begin
      applyStimulus(1'b0, "t3on");
      checkEq("t3onack", 32'(bus.ack),        32'(maskOf(i)));
      checkEq("t3oncnt", 32'(bus.active_cnt), 32'(i + 1));
      applyStimulus(1'b0, "t3onhold");
    end
    reqHold = 4'b1111;
    onHold  = 4'b0000;
    for (int i = 0; i < N; i++) begin
      applyStimulus(1'b0, "t3off");
      checkEq("t3offack", 32'(bus.ack),        32'(maskOf(i)));
      checkEq("t3offdir", 32'(bus.on_off),     32'd0);
      checkEq("t3offcnt", 32'(bus.active_cnt), 32'(N - 1 - i));
      applyStimulus(1'b0, "t3offhold");
    end

    // Fairness: devices 1 and 3 keep re-requesting and must alternate
    onHold = 4'b1010;
    for (int i = 0; i < 6; i++) begin
      reqHold = reqHold | 4'b1010;
      applyStimulus(1'b0, "t4grant");
      checkEq("t4ack", 32'(bus.ack), (i % 2 == 0) ? 32'd2 : 32'd8);
      reqHold = reqHold | 4'b1010;
      applyStimulus(1'b0, "t4hold");
    end
    reqHold = '0;
    applyStimulus(1'b0, "t4drain");

    // Clear during HOLD with map 0110, device 0 pending through the clear
    applyStimulus(1'b1, "t5clr0");
    reqHold = 4'b0010;
    onHold  = 4'b0110;
    applyStimulus(1'b0, "t5g1");
    applyStimulus(1'b0, "t5h1");
    reqHold = 4'b0100;
    applyStimulus(1'b0, "t5g2");
    checkEq("t5map", 32'(bus.active_map), 32'h6);
    reqHold = 4'b0001;
    onHold  = 4'b0111;
    applyStimulus(1'b1, "t5clr");
    checkEq("t5monrst", 32'(bus.mon_rst),    32'd1);
    checkEq("t5map0",   32'(bus.active_map), 32'd0);
    checkEq("t5ack0",   32'(bus.ack),        32'd0);
    applyStimulus(1'b0, "t5after");
    checkEq("t5ackdev0", 32'(bus.ack),     32'd1);
    checkEq("t5monrst0", 32'(bus.mon_rst), 32'd0);
    applyStimulus(1'b0, "t5hold");

    // Asynchronous reset while an event is on the wire
    reqHold = 4'b0010;
    onHold  = 4'b0011;
    applyStimulus(1'b0, "t6grant");
    checkEq("t6change", 32'(bus.change), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkEq("t6rstchg", 32'(bus.change),     32'd0);
    checkEq("t6rstack", 32'(bus.ack),        32'd0);
    checkEq("t6rstmap", 32'(bus.active_map), 32'd0);
    checkOutput("t6rst");
    #2;
    rst_n   = 1'b1;
    reqHold = 4'b1111;
    onHold  = 4'b1111;
    applyStimulus(1'b0, "t6after");
    checkEq("t6first", 32'(bus.ack), 32'd1);
    applyStimulus(1'b0, "t6hold");
    $display("[TB] directed steps done");

    // Randomized traffic with occasional clears
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!bitOf(reqHold, i) && $urandom_range(0, 99) < 35) begin
          reqHold = reqHold | maskOf(i);
          onHold  = ($urandom_range(0, 1) != 0) ? (onHold | maskOf(i)) : (onHold & ~maskOf(i));
        end
      end
      applyStimulus($urandom_range(0, 99) < 4, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iot_event_arbiter.md
Name: iot_event_arbiter

Overview:
- Shares the single-event input of the active-IoT-device monitor counter among N_DEV device requesters.
- Arbitrates pending on/off requests round-robin and issues one single-cycle change/on_off event per accepted request.
- Tracks each device's on/off state and suppresses redundant events (ON while already on, OFF while already off), so the monitor count stays equal to the number of active devices.
- Provides a synchronous clear that resets the monitor and the state map together.

Parameters:
- N_DEV, 4, number of device requesters (2..16).
- CW, 5, width of active_cnt; must satisfy 2^CW > N_DEV.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_DEV  per-device request, level; held high until its ack.
- req_on  in  N_DEV  requested state per device (1=on, 0=off); stable while req high.
- clr  in  1  synchronous clear of device state and monitor.
- ack  out  N_DEV  one-cycle grant acknowledge, one-hot or zero.
- change  out  1  to monitor change input; one-cycle pulse.
- on_off  out  1  to monitor on_off input; valid when change=1.
- mon_rst  out  1  to monitor rst input; one-cycle pulse.
- active_map  out  N_DEV  current on/off state per device.
- active_cnt  out  CW  population count of active_map.
- busy  out  1  1 while FSM is in HOLD.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, ptr=N_DEV-1. ack, change, on_off, mon_rst, active_map, active_cnt and busy are all 0.
- All outputs are registered. No combinational path from inputs to outputs.
- FSM states: IDLE and HOLD.
- IDLE, clr=0, req!=0:
  - Winner w = first i with req[i]=1, searching ptr+1, ptr+2, ... modulo N_DEV.
  - At the clock edge: ack[w]<=1, ptr<=w, busy<=1, state<=HOLD.
  - If req_on[w]!=active_map[w]: change<=1, on_off<=req_on[w], active_map[w]<=req_on[w], active_cnt updated by +1 or -1.
  - Otherwise (redundant request): change<=0, on_off<=0, active_map unchanged.
- IDLE, req=0: all pulse outputs go to 0; stay in IDLE.
- HOLD, clr=0: ack<=0, change<=0, busy<=0, state<=IDLE. req is not sampled in HOLD.
- Handshake:
  - The requester sees ack for exactly 1 cycle and must drop req on the edge after ack.
  - A req still high when IDLE is next entered is treated as a new request.
- Throughput: at most one event per 2 cycles. Latency from req seen in IDLE to change/ack high is 1 cycle.
- Fairness: a continuously requesting device waits at most N_DEV-1 grants.
- clr=1 at any edge, in any state, takes priority over everything else:
  - mon_rst<=1 for that cycle; active_map<=0; active_cnt<=0.
  - ack<=0, change<=0, busy<=0, state<=IDLE; ptr unchanged.
  - No grant is made in that cycle. A pending req stays pending and is arbitrated after clr drops.
- mon_rst returns to 0 on the first edge with clr=0.
- Wrap-around is impossible by construction: active_cnt is always in 0..N_DEV and matches the monitor count.
- Reset asserted mid-operation: all outputs clear immediately (async). The in-flight event is lost and the requester re-arbitrates after reset.
- Simultaneous req on all devices: granted in rotating order from ptr+1.

Test Plan:
- Reset, then req[0]=1 with req_on[0]=1 → after 1 edge: ack=0001, change=1, on_off=1, active_map=0001, active_cnt=1; after the next edge: ack=0, change=0.
- req[2] ON accepted, then req[2] ON again → second grant gives ack[2]=1, change=0; active_cnt stays 1.
- req=1111, all req_on=1, held and each bit dropped after its ack → ack order 0001, 0010, 0100, 1000 on every other cycle; active_cnt goes 1, 2, 3, 4. Then all OFF → active_cnt goes 3, 2, 1, 0 with on_off=0.
- Fairness: req[1] held continuously and re-raised after each ack, with req[3] pending → grants alternate between 1 and 3; ptr wraps 3→0.
- clr=1 while in HOLD with active_map=0110 → next cycle mon_rst=1, active_map=0, active_cnt=0, ack=0, state=IDLE. A req held through clr is granted after clr drops.
- rst_n pulled low during HOLD with change=1 → change, ack and active_map go to 0 immediately; after release the first grant goes to device 0.
